systolic_batch_ctrl: RTL and testbench

//   Controller for a SIZE x SIZE systolic MAC array fed by per-row X and W FIFOs.

---
 rtl/systolic_batch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_systolic_batch_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_batch_ctrl.sv
// Batch controller for a SIZE x SIZE systolic MAC array fed by per-row X/W FIFOs.
// Sequences LOAD -> MAC (skewed reads) -> DRAIN -> OUT (row handoff) and restarts.
module systolic_batch_ctrl #(
    parameter int unsigned SIZE  = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned CW   = $clog2(DEPTH + SIZE) + 1,
    localparam int unsigned RW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            x_send_val,
    output logic            x_send_rdy,
    input  logic            w_send_val,
    output logic            w_send_rdy,
    input  logic [SIZE-1:0] x_fifo_full,
    input  logic [SIZE-1:0] x_fifo_empty,
    output logic [SIZE-1:0] x_fifo_wen,
    output logic [SIZE-1:0] x_fifo_ren,
    input  logic [SIZE-1:0] w_fifo_full,
    input  logic [SIZE-1:0] w_fifo_empty,
    output logic [SIZE-1:0] w_fifo_wen,
    output logic [SIZE-1:0] w_fifo_ren,
    output logic            mac_en,
    output logic            acc_clr,
    output logic            out_val,
    input  logic            out_rdy,
    output logic [RW-1:0]   out_row,
    output logic            busy,
    output logic            err
);

    localparam logic [CW-1:0] MAC_LAST   = CW'(DEPTH + SIZE - 2);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(SIZE - 1);
    localparam logic [CW-1:0] DEPTH_CW   = CW'(DEPTH);
    localparam logic [RW-1:0] ROW_LAST   = RW'(SIZE - 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [RW-1:0]   row_q, row_d;
    logic            err_q, err_d;

    logic            all_full;
    logic [SIZE-1:0] skew_ren;
    logic            x_rdy_c, w_rdy_c;
    logic [SIZE-1:0] x_wen_c, w_wen_c, ren_c;
    logic            mac_en_c, acc_clr_c, out_val_c;
    logic            rd_err;

    assign all_full = (&x_fifo_full) & (&w_fifo_full);

    // Row i reads while 0 <= cnt-i < DEPTH; cnt<i wraps to a value above DEPTH.
    always_comb begin
        skew_ren = '0;
        for (int unsigned i = 0; i < SIZE; i++) begin
            skew_ren[i] = (cnt_q - CW'(i)) < DEPTH_CW;
        end
    end

    assign rd_err = |((x_fifo_ren & x_fifo_empty) | (w_fifo_ren & w_fifo_empty));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        err_d     = err_q | rd_err;
        x_rdy_c   = 1'b0;
        w_rdy_c   = 1'b0;
        x_wen_c   = '0;
        w_wen_c   = '0;
        ren_c     = '0;
        mac_en_c  = 1'b0;
        acc_clr_c = 1'b0;
        out_val_c = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                x_rdy_c = !all_full;
                w_rdy_c = !all_full;
                x_wen_c = {SIZE{x_send_val & x_rdy_c}};
                w_wen_c = {SIZE{w_send_val & w_rdy_c}};
                if (all_full) begin
                    state_d = S_MAC;
                    cnt_d   = '0;
                end
            end
            S_MAC: begin
                ren_c    = skew_ren;
                mac_en_c = 1'b1;
                if (cnt_q == MAC_LAST) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DRAIN: begin
                mac_en_c = 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = S_OUT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_OUT: begin
                out_val_c = 1'b1;
                if (out_rdy) begin
                    if (row_q == ROW_LAST) begin
                        acc_clr_c = 1'b1;
                        state_d   = S_LOAD;
                        row_d     = '0;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: begin
                state_d = S_LOAD;
                cnt_d   = '0;
                row_d   = '0;
            end
        endcase
    end

    // Every output is forced low while reset is asserted.
    assign x_send_rdy = rst_n & x_rdy_c;
    assign w_send_rdy = rst_n & w_rdy_c;
    assign x_fifo_wen = rst_n ? x_wen_c : '0;
    assign w_fifo_wen = rst_n ? w_wen_c : '0;
    assign x_fifo_ren = rst_n ? ren_c : '0;
    assign w_fifo_ren = rst_n ? ren_c : '0;
    assign mac_en     = rst_n & mac_en_c;
    assign acc_clr    = rst_n & acc_clr_c;
    assign out_val    = rst_n & out_val_c;
    assign out_row    = rst_n ? row_q : '0;
    assign busy       = rst_n & (state_q != S_LOAD);
    assign err        = rst_n & err_q;

endmodule

// File: tb/tb_systolic_batch_ctrl.sv
// Directed bench for systolic_batch_ctrl (SIZE=4, DEPTH=4) with a FIFO occupancy model
// and a per-cycle scoreboard of expected control outputs.
module tb_systolic_batch_ctrl;

    localparam int unsigned SZ   = 4;
    localparam int unsigned DP   = 4;
    localparam int unsigned MACN = DP + SZ - 1;
    localparam int unsigned MD   = MACN + SZ;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          x_send_val, w_send_val, x_send_rdy, w_send_rdy;
    logic [SZ-1:0] x_fifo_full, x_fifo_empty, x_fifo_wen, x_fifo_ren;
    logic [SZ-1:0] w_fifo_full, w_fifo_empty, w_fifo_wen, w_fifo_ren;
    logic          mac_en, acc_clr, out_val, out_rdy, busy, err;
    logic [1:0]    out_row;

    typedef struct packed {
        logic [SZ-1:0] xren;
        logic [SZ-1:0] wren;
        logic          mac_en;
        logic          busy;
        logic          xrdy;
        logic          wrdy;
        logic          out_val;
        logic          acc_clr;
        logic          err;
        logic [1:0]    row;
    } obs_t;

    obs_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   x_occ[SZ];
    int   w_occ[SZ];
    bit   force_e1 = 1'b0;

    always #5 clk = ~clk;

    systolic_batch_ctrl #(.SIZE(SZ), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .x_send_val(x_send_val), .x_send_rdy(x_send_rdy),
        .w_send_val(w_send_val), .w_send_rdy(w_send_rdy),
        .x_fifo_full(x_fifo_full), .x_fifo_empty(x_fifo_empty),
        .x_fifo_wen(x_fifo_wen), .x_fifo_ren(x_fifo_ren),
        .w_fifo_full(w_fifo_full), .w_fifo_empty(w_fifo_empty),
        .w_fifo_wen(w_fifo_wen), .w_fifo_ren(w_fifo_ren),
        .mac_en(mac_en), .acc_clr(acc_clr),
        .out_val(out_val), .out_rdy(out_rdy), .out_row(out_row),
        .busy(busy), .err(err)
    );

    function automatic int occ_next(input int o, input logic we, input logic re);
        int n;
        n = o + (we ? 1 : 0) - (re ? 1 : 0);
        if (n > int'(DP)) n = int'(DP);
        if (n < 0) n = 0;
        return n;
    endfunction

    // FIFO bank model: occupancy only, saturating at DEPTH and 0.
    always @(posedge clk) begin
        for (int i = 0; i < int'(SZ); i++) begin
            x_occ[i] <= occ_next(x_occ[i], x_fifo_wen[i], x_fifo_ren[i]);
            w_occ[i] <= occ_next(w_occ[i], w_fifo_wen[i], w_fifo_ren[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(SZ); i++) begin
            x_fifo_full[i]  = (x_occ[i] == int'(DP));
            x_fifo_empty[i] = (x_occ[i] == 0);
            w_fifo_full[i]  = (w_occ[i] == int'(DP));
            w_fifo_empty[i] = (w_occ[i] == 0);
        end
        x_fifo_empty[1] = x_fifo_empty[1] | force_e1;
    end

    function automatic obs_t observe();
        obs_t o;
        o.xren    = x_fifo_ren;
        o.wren    = w_fifo_ren;
        o.mac_en  = mac_en;
        o.busy    = busy;
        o.xrdy    = x_send_rdy;
        o.wrdy    = w_send_rdy;
        o.out_val = out_val;
        o.acc_clr = acc_clr;
        o.err     = err;
        o.row     = out_row;
        return o;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_total++;
        assert (got === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({x_send_rdy, w_send_rdy, x_fifo_wen, x_fifo_ren, w_fifo_wen, w_fifo_ren,
                    mac_en, acc_clr, out_val, out_row, busy, err});
    endfunction

    // Drive both streams until the controller stops accepting; bounded wait.
    task automatic load(input int exp_writes);
        int nx = 0;
        bit done = 1'b0;
        for (int c = 0; c < int'(3 * DP + 4) && !done; c++) begin
            @(negedge clk);
            x_send_val = 1'b1;
            w_send_val = 1'b1;
            #1;
            if (x_send_rdy && w_send_rdy) begin
                if (nx == 0) check("load_wen", 32'({x_fifo_wen, w_fifo_wen}), 32'({(2 * SZ){1'b1}}));
                nx++;
            end else begin
                check("wen_held_off", 32'({x_fifo_wen, w_fifo_wen}), 32'd0);
                done = 1'b1;
            end
        end
        x_send_val = 1'b0;
        w_send_val = 1'b0;
        check("load_done", 32'(done), 32'd1);
        check("load_writes", 32'(nx), 32'(exp_writes));
    endtask

    task automatic push_batch(input int bp);
        obs_t e;
        for (int t = 0; t < int'(MACN); t++) begin
            e = '0;
            for (int i = 0; i < int'(SZ); i++) begin
                e.xren[i] = (t >= i) && (t < i + int'(DP));
                e.wren[i] = e.xren[i];
            end
            e.mac_en = 1'b1;
            e.busy   = 1'b1;
            exp_q.push_back(e);
        end
        for (int t = 0; t < int'(SZ); t++) begin
            e = '0;
            e.mac_en = 1'b1;
            e.busy   = 1'b1;
            exp_q.push_back(e);
        end
        for (int j = 0; j < bp; j++) begin
            e = '0;
            e.busy    = 1'b1;
            e.out_val = 1'b1;
            exp_q.push_back(e);
        end
        for (int r = 0; r < int'(SZ); r++) begin
            e = '0;
            e.busy    = 1'b1;
            e.out_val = 1'b1;
            e.row     = 2'(r);
            e.acc_clr = (r == int'(SZ) - 1);
            exp_q.push_back(e);
        end
        e = '0;
        e.xrdy = 1'b1;
        e.wrdy = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic run_queue(input int bp, input string name);
        obs_t got, e;
        int k = 0;
        int rcnt[SZ];
        int mcnt = 0;
        for (int i = 0; i < int'(SZ); i++) rcnt[i] = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            out_rdy = (k >= int'(MD) + bp);
            #1;
            got = observe();
            e   = exp_q.pop_front();
            check($sformatf("%s_cyc%0d", name, k), 32'(got), 32'(e));
            for (int i = 0; i < int'(SZ); i++) rcnt[i] += int'(got.xren[i]);
            mcnt += int'(got.mac_en);
            k++;
        end
        out_rdy = 1'b0;
        for (int i = 0; i < int'(SZ); i++)
            check($sformatf("%s_reads_row%0d", name, i), 32'(rcnt[i]), 32'(DP));
        check({name, "_mac_en_cycles"}, 32'(mcnt), 32'd11);
    endtask

    initial begin
        rst_n      = 1'b0;
        x_send_val = 1'b1;
        w_send_val = 1'b1;
        out_rdy    = 1'b1;

        repeat (2) begin
            @(negedge clk);
            #1;
            check("reset_outputs_zero", all_outs(), 32'd0);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        x_send_val = 1'b0;
        w_send_val = 1'b0;
        out_rdy    = 1'b0;
        #1;
        check("idle_rdy", 32'({x_send_rdy, w_send_rdy, busy, err}), 32'b1100);

        // Batch 1 with 5 cycles of output backpressure, batch 2 without.
        load(int'(DP));
        push_batch(5);
        run_queue(5, "b1");
        load(int'(DP));
        push_batch(0);
        run_queue(0, "b2");

        // Reset asserted while cnt=2 in MAC.
        load(int'(DP));
        @(negedge clk); #1;
        check("mid_t0_ren", 32'({x_fifo_ren, w_fifo_ren}), 32'b0001_0001);
        @(negedge clk); #1;
        check("mid_t1_ren", 32'({x_fifo_ren, w_fifo_ren}), 32'b0011_0011);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outputs_zero", all_outs(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_after_rst", 32'({x_fifo_ren, w_fifo_ren, mac_en, busy}), 32'd0);
        check("mid_after_rst_rdy", 32'(x_send_rdy), 32'd1);

        // Rows 0/1 were partly drained, so two writes refill every FIFO.
        load(2);
        @(negedge clk); #1;
        check("err_t0", 32'(err), 32'd0);
        @(negedge clk); #1;
        @(negedge clk);
        force_e1 = 1'b1;
        #1;
        check("err_ren1", 32'(x_fifo_ren[1]), 32'd1);
        check("err_not_yet", 32'(err), 32'd0);
        @(negedge clk);
        force_e1 = 1'b0;
        #1;
        check("err_set", 32'(err), 32'd1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); #1;
            check($sformatf("err_sticky%0d", c), 32'(err), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("err_cleared", 32'({err, busy}), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
